// File: rtl/apb_cfg_master.sv
// apb_cfg_master: APB3 initiator turning a valid/ready command stream into single
//   APB3 transfers, one valid/ready response per command, one transfer outstanding.
// Latency: accept -> SETUP -> ACCESS -> response; each PREADY=0 cycle adds one cycle.
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready.
// Ports: cmd_* command in, rsp_* response out, busy, APB3 master signals P*.
// Optional build macro APB_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_cfg_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state, state_d;
  logic                    psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_d;
  logic                    rsp_valid_d, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
  logic             wait_limit;
  logic             rsp_timeout_q, rsp_timeout_d;

  // True on the wait cycle that would bring the count up to TIMEOUT_CYCLES.
  assign wait_limit  = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d    = wait_cnt;
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_addr[1:0] == 2'b00) begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = cmd_write;
            paddr_d   = cmd_addr;
            pwdata_d  = cmd_wdata;
          end else begin
            // Misaligned: answer with an error without touching the bus.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
`ifdef APB_TIMEOUT_EN
            rsp_timeout_d = 1'b0;
`endif
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        // PREADY takes priority over the timeout limit on the same cycle.
        if (PREADY) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = PWRITE ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
`ifdef APB_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (wait_limit) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt      <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cmd_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt      <= wait_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

endmodule
